// File: rtl/led_pkg.sv
// Shared definitions for the LED mode controller: mode encodings, the
// active LED polarity and a width helper used to size counters.
// Build option: LED_ACTIVE_HIGH_EN selects an active-high LED polarity.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_BREATH = 2'd2,
        MODE_BLINK  = 2'd3
    } led_mode_e;

`ifdef LED_ACTIVE_HIGH_EN
    localparam logic LED_LIT = 1'b1;
`else
    localparam logic LED_LIT = 1'b0;
`endif
    localparam logic LED_DARK = ~LED_LIT;

    // Number of bits required to hold the value itself (not value-1).
    function automatic int get_width(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((value >> i) != 32'sd0) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/led_seq_ch.sv
// One LED channel: mode, brightness level and ramp direction registers.
// The level only moves on the period tick, so the PWM compare always sees
// a whole period at one duty cycle. The LED output is registered from the
// next-cycle counter and level so it lines up with the shared counter.
module led_seq_ch
    import led_pkg::*;
#(
    parameter int CNT_NUM   = 2400,
    parameter int CNT_WIDTH = get_width(CNT_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 blink_phase_nxt,
    input  logic [CNT_WIDTH-1:0] cnt_nxt,
    input  logic                 apply,
    input  led_mode_e            apply_mode,
    output led_mode_e            mode,
    output logic                 led
);

    localparam logic [CNT_WIDTH-1:0] LVL_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] LVL_MAX  = CNT_WIDTH'(CNT_NUM);
    localparam logic [CNT_WIDTH-1:0] LVL_TOP  = CNT_WIDTH'(CNT_NUM - 1);
    localparam logic [CNT_WIDTH-1:0] LVL_ONE  = CNT_WIDTH'(1);

    led_mode_e            mode_q,  mode_d;
    logic [CNT_WIDTH-1:0] level_q, level_d;
    logic                 dir_q,   dir_d;
    logic                 led_q,   led_d;

    // Per-tick level update: a freshly applied mode wins over normal stepping.
    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        dir_d   = dir_q;
        if (tick) begin
            if (apply) begin
                mode_d = apply_mode;
                case (apply_mode)
                    MODE_OFF:    level_d = LVL_ZERO;
                    MODE_ON:     level_d = LVL_MAX;
                    MODE_BLINK:  level_d = blink_phase_nxt ? LVL_MAX : LVL_ZERO;
                    MODE_BREATH: begin
                        // Restart the triangle from the bottom, climbing.
                        level_d = LVL_ZERO;
                        dir_d   = 1'b0;
                    end
                    default:     level_d = LVL_ZERO;
                endcase
            end else begin
                case (mode_q)
                    MODE_OFF:    level_d = LVL_ZERO;
                    MODE_ON:     level_d = LVL_MAX;
                    MODE_BLINK:  level_d = blink_phase_nxt ? LVL_MAX : LVL_ZERO;
                    MODE_BREATH: begin
                        // Each extreme is held for one tick while the direction flips.
                        if (!dir_q) begin
                            if (level_q >= LVL_TOP) begin
                                dir_d = 1'b1;
                            end else begin
                                level_d = level_q + LVL_ONE;
                            end
                        end else begin
                            if (level_q == LVL_ZERO) begin
                                dir_d = 1'b0;
                            end else begin
                                level_d = level_q - LVL_ONE;
                            end
                        end
                    end
                    default:     level_d = LVL_ZERO;
                endcase
            end
        end else begin
            level_d = level_q;
        end
        led_d = (cnt_nxt < level_d) ? LED_LIT : LED_DARK;
    end

    // Channel state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= MODE_OFF;
            level_q <= LVL_ZERO;
            dir_q   <= 1'b0;
            led_q   <= LED_DARK;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
        end
    end

    assign mode = mode_q;
    assign led  = led_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Multi-channel LED mode controller. A shared PWM period counter drives
// CH_NUM channel sequencers; a one-entry command slot defers mode changes
// to the next period boundary so no channel ever sees a partial period.
// Build option: LED_ACTIVE_HIGH_EN (see led_pkg) inverts LED polarity.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int CH_NUM    = 4,
    parameter int CNT_NUM   = 2400,
    parameter int BLINK_DIV = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_ch,
    input  logic [1:0]          cmd_mode,
    output logic [CH_NUM-1:0]   led,
    output logic [2*CH_NUM-1:0] ch_mode,
    output logic                tick
);

    localparam int CNT_WIDTH = get_width(CNT_NUM);
    localparam int BLK_WIDTH = get_width(BLINK_DIV);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_NUM - 1);
    localparam logic [BLK_WIDTH-1:0] BLK_LAST = BLK_WIDTH'(BLINK_DIV - 1);
    // With a one-cycle period every cycle ends a period.
    localparam logic TICK_RST = (CNT_NUM == 1) ? 1'b1 : 1'b0;

    logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;
    logic                 tick_q,      tick_d;
    logic [BLK_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic                 pend_q,      pend_d;
    logic [3:0]           pend_ch_q,   pend_ch_d;
    led_mode_e            pend_mode_q, pend_mode_d;
    logic                 apply_s;

    // Period counter wrap and the registered end-of-period flag.
    always_comb begin
        if (tick_q) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        tick_d = (cnt_d == CNT_LAST);
    end

    // Blink divider: the phase flips on every BLINK_DIV-th period tick.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick_q) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = {BLK_WIDTH{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BLK_WIDTH'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Command slot: capture when empty, release on the next period tick.
    // A capture and a release can never coincide because ready is low
    // whenever the slot is full.
    always_comb begin
        pend_d      = pend_q;
        pend_ch_d   = pend_ch_q;
        pend_mode_d = pend_mode_q;
        apply_s     = 1'b0;
        if (pend_q) begin
            if (tick_q) begin
                apply_s = 1'b1;
                pend_d  = 1'b0;
            end else begin
                pend_d  = 1'b1;
            end
        end else if (cmd_valid) begin
            pend_d      = 1'b1;
            pend_ch_d   = cmd_ch;
            pend_mode_d = led_mode_e'(cmd_mode);
        end else begin
            pend_d = 1'b0;
        end
    end

    // Shared timing and command registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= {CNT_WIDTH{1'b0}};
            tick_q        <= TICK_RST;
            blink_cnt_q   <= {BLK_WIDTH{1'b0}};
            blink_phase_q <= 1'b0;
            pend_q        <= 1'b0;
            pend_ch_q     <= 4'd0;
            pend_mode_q   <= MODE_OFF;
        end else begin
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pend_q        <= pend_d;
            pend_ch_q     <= pend_ch_d;
            pend_mode_q   <= pend_mode_d;
        end
    end

    assign tick      = tick_q;
    assign cmd_ready = ~pend_q;

    // Out-of-range channel indices match no instance and are simply dropped.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        led_mode_e mode_s;
        logic      apply_ch_s;

        assign apply_ch_s = apply_s && (pend_ch_q == 4'(i));

        led_seq_ch #(
            .CNT_NUM   (CNT_NUM),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk             (clk),
            .rst             (rst),
            .tick            (tick_q),
            .blink_phase_nxt (blink_phase_d),
            .cnt_nxt         (cnt_d),
            .apply           (apply_ch_s),
            .apply_mode      (pend_mode_q),
            .mode            (mode_s),
            .led             (led[i])
        );

        assign ch_mode[2*i +: 2] = mode_s;
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with CH_NUM=2, CNT_NUM=4, BLINK_DIV=2.
// The reference model tracks period position, tick count and per-channel
// mode; breath level is derived from ticks elapsed since the ramp started.
module tb_led_seq_ctrl;

    localparam int CH = 2;
    localparam int CN = 4;
    localparam int BD = 2;
`ifdef LED_ACTIVE_HIGH_EN
    localparam logic LIT = 1'b1;
`else
    localparam logic LIT = 1'b0;
`endif
    localparam logic DARK = ~LIT;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [3:0]      cmd_ch = 4'd0;
    logic [1:0]      cmd_mode = 2'd0;
    logic [CH-1:0]   led;
    logic [2*CH-1:0] ch_mode;
    logic            tick;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_pos, m_ticks, m_pch, m_pmode;
    bit m_pend, m_fired;
    int m_mode  [CH];
    int m_start [CH];

    led_seq_ctrl #(.CH_NUM(CH), .CNT_NUM(CN), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .led(led), .ch_mode(ch_mode), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pos = 0; m_ticks = 0; m_pend = 0; m_fired = 0; m_pch = 0; m_pmode = 0;
        for (int i = 0; i < CH; i++) begin m_mode[i] = 0; m_start[i] = 0; end
    endtask

    function automatic int exp_level(input int i);
        int p;
        case (m_mode[i])
            0: return 0;
            1: return CN;
            3: return (((m_ticks / BD) % 2) == 1) ? CN : 0;
            default: begin
                p = (m_ticks - m_start[i]) % (2 * CN);
                return (p < CN) ? p : (2 * CN - 1 - p);
            end
        endcase
    endfunction

    function automatic logic [3*CH+1:0] exp_vec();
        logic [CH-1:0]   l;
        logic [2*CH-1:0] m;
        for (int i = 0; i < CH; i++) begin
            l[i]       = (m_pos < exp_level(i)) ? LIT : DARK;
            m[2*i +: 2] = 2'(m_mode[i]);
        end
        return {l, m, 1'(!m_pend), 1'(m_pos == CN - 1)};
    endfunction

    // Advance one clock; model consumes the inputs seen at the edge.
    task automatic step();
        bit fire, tk;
        @(posedge clk);
        fire = cmd_valid && !m_pend;
        tk   = (m_pos == CN - 1);
        if (tk) begin
            m_ticks++;
            if (m_pend) begin
                if (m_pch < CH) begin
                    m_mode[m_pch] = m_pmode;
                    if (m_pmode == 2) m_start[m_pch] = m_ticks;
                end
                m_pend = 0;
            end
        end
        if (fire) begin m_pend = 1; m_pch = int'(cmd_ch); m_pmode = int'(cmd_mode); end
        m_fired = fire;
        m_pos = (m_pos + 1) % CN;
        @(negedge clk);
    endtask

    // Hold a command until it is accepted (bounded).
    task automatic send_cmd(input int ch, input int mode);
        bit seen;
        cmd_valid = 1'b1; cmd_ch = 4'(ch); cmd_mode = 2'(mode);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            seen = (cmd_ready === 1'b1);
            step();
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL send_cmd: cmd_ready=%b, required 1 within 40 cycles", cmd_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (led !== {CH{DARK}} || ch_mode !== 4'd0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_hold: led=%b ch_mode=%h ready=%b, required led=%b ch_mode=0 ready=1", led, ch_mode, cmd_ready, {CH{DARK}});
        end
        rst = 1'b1; model_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            n_tests++;
            if (tick !== 1'(k % 4 == 3)) begin n_fail++; $display("FAIL reset_tick k=%0d: got %b required %b", k, tick, 1'(k % 4 == 3)); end
            n_tests++;
            if ({led, ch_mode, cmd_ready, tick} !== exp_vec()) begin n_fail++; $display("FAIL reset_vec k=%0d: got %h required %h", k, {led, ch_mode, cmd_ready, tick}, exp_vec()); end
        end
    endtask

    task automatic test_breath();
        int tab [10] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
        int lit;
        send_cmd(0, 2);
        for (int k = 0; k < 20 && m_mode[0] != 2; k++) step();
        n_tests++;
        if (ch_mode[1:0] !== 2'd2) begin n_fail++; $display("FAIL breath_mode: got %0d required 2", ch_mode[1:0]); end
        for (int p = 0; p < 10; p++) begin
            lit = 0;
            for (int c = 0; c < CN; c++) begin
                if (led[0] === LIT) lit++;
                n_tests++;
                if ({led, ch_mode, cmd_ready, tick} !== exp_vec()) begin n_fail++; $display("FAIL breath_vec p=%0d c=%0d: got %h required %h", p, c, {led, ch_mode, cmd_ready, tick}, exp_vec()); end
                step();
            end
            n_tests++;
            if (lit != tab[p]) begin n_fail++; $display("FAIL breath_level p=%0d: got %0d lit cycles required %0d", p, lit, tab[p]); end
        end
    endtask

    task automatic test_on_off();
        send_cmd(1, 1);
        for (int k = 0; k < 20 && m_mode[1] != 1; k++) step();
        for (int c = 0; c < CN; c++) begin
            n_tests++;
            if (led[1] !== LIT) begin n_fail++; $display("FAIL on_lit c=%0d: got %b required %b", c, led[1], LIT); end
            step();
        end
        send_cmd(1, 0);
        for (int k = 0; k < 20 && m_mode[1] != 0; k++) step();
        for (int c = 0; c < CN; c++) begin
            n_tests++;
            if (led[1] !== DARK) begin n_fail++; $display("FAIL off_dark c=%0d: got %b required %b", c, led[1], DARK); end
            n_tests++;
            if ({led, ch_mode, cmd_ready, tick} !== exp_vec()) begin n_fail++; $display("FAIL off_vec c=%0d: got %h required %h", c, {led, ch_mode, cmd_ready, tick}, exp_vec()); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_ch = 4'd0; cmd_mode = 2'd1;
        for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) step();
        step();
        cmd_mode = 2'd0;
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hs_busy: cmd_ready=%b required 0", cmd_ready); end
        for (int k = 0; k < 20 && ch_mode[1:0] !== 2'd1; k++) begin
            n_tests++;
            if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hs_hold: cmd_ready=%b required 0", cmd_ready); end
            step();
        end
        n_tests++;
        if (ch_mode[1:0] !== 2'd1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hs_apply: mode=%0d ready=%b required mode=1 ready=1", ch_mode[1:0], cmd_ready); end
        step();
        cmd_valid = 1'b0;
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hs_b2b: cmd_ready=%b required 0", cmd_ready); end
        for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) step();
        n_tests++;
        if (ch_mode[1:0] !== 2'd0) begin n_fail++; $display("FAIL hs_second: mode=%0d required 0", ch_mode[1:0]); end
        // command captured in a tick cycle waits a full period
        for (int k = 0; k < 8 && m_pos != CN - 1; k++) step();
        n_tests++;
        if (tick !== 1'b1) begin n_fail++; $display("FAIL hs_tick_align: tick=%b required 1", tick); end
        cmd_valid = 1'b1; cmd_ch = 4'd1; cmd_mode = 2'd1;
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (ch_mode[3:2] !== 2'd0) begin n_fail++; $display("FAIL hs_tickcmd_wait c=%0d: mode=%0d required 0", c, ch_mode[3:2]); end
            if (c < 3) step();
        end
        step();
        n_tests++;
        if (ch_mode[3:2] !== 2'd1) begin n_fail++; $display("FAIL hs_tickcmd_apply: mode=%0d required 1", ch_mode[3:2]); end
    endtask

    task automatic test_blink();
        logic v;
        int len;
        send_cmd(0, 3);
        for (int k = 0; k < 20 && m_mode[0] != 3; k++) step();
        v = led[0];
        for (int k = 0; k < 20 && led[0] === v; k++) step();
        for (int r = 0; r < 3; r++) begin
            v = led[0]; len = 1;
            step();
            for (int k = 0; k < 20 && led[0] === v; k++) begin len++; step(); end
            n_tests++;
            if (len != 8) begin n_fail++; $display("FAIL blink_run r=%0d: got %0d cycles required 8", r, len); end
            n_tests++;
            if ({led, ch_mode, cmd_ready, tick} !== exp_vec()) begin n_fail++; $display("FAIL blink_vec r=%0d: got %h required %h", r, {led, ch_mode, cmd_ready, tick}, exp_vec()); end
        end
        send_cmd(3, 1);
        repeat (8) step();
        n_tests++;
        if (ch_mode !== 4'b0111 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ch: ch_mode=%h ready=%b required 7 ready=1", ch_mode, cmd_ready); end
    endtask

    task automatic test_reset_mid();
        send_cmd(1, 2);
        repeat (10) step();
        send_cmd(0, 1);
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pending: cmd_ready=%b required 0", cmd_ready); end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (led !== {CH{DARK}} || ch_mode !== 4'd0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: led=%b ch_mode=%h ready=%b required led=%b 0 1", led, ch_mode, cmd_ready, {CH{DARK}});
        end
        @(negedge clk);
        rst = 1'b1; model_reset();
        for (int k = 0; k < 12; k++) begin
            step();
            n_tests++;
            if ({led, ch_mode, cmd_ready, tick} !== exp_vec()) begin n_fail++; $display("FAIL mid_vec k=%0d: got %h required %h", k, {led, ch_mode, cmd_ready, tick}, exp_vec()); end
        end
        n_tests++;
        if (ch_mode !== 4'd0 || led !== {CH{DARK}}) begin n_fail++; $display("FAIL mid_lost: ch_mode=%h led=%b required 0 and dark", ch_mode, led); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (!cmd_valid || m_fired) begin
                if ($urandom_range(0, 2) == 0) begin
                    cmd_valid = 1'b1;
                    cmd_ch    = 4'($urandom_range(0, 3));
                    cmd_mode  = 2'($urandom_range(0, 3));
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            step();
            n_tests++;
            if ({led, ch_mode, cmd_ready, tick} !== exp_vec()) begin n_fail++; $display("FAIL random_vec k=%0d: got %h required %h", k, {led, ch_mode, cmd_ready, tick}, exp_vec()); end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_breath();
        test_on_off();
        test_back_to_back();
        test_blink();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Multi-channel LED mode controller and scheduler. One PWM period counter is shared by CH_NUM LED outputs. Each channel runs its own level sequencer: off, on, breathe (triangular ramp) or blink. A valid/ready command port sets channel modes, and a new mode takes effect only at a PWM period boundary, so no output ever sees a glitched duty cycle.

Parameters:
CH_NUM, 4, number of LED channels (1..16)
CNT_NUM, 2400, clock cycles per PWM period; also the number of brightness steps
BLINK_DIV, 250, PWM periods per blink half-phase (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_ch  input  4  target channel index
cmd_mode  input  2  0=OFF 1=ON 2=BREATH 3=BLINK
led  output  CH_NUM  per-channel PWM output, active-low by default
ch_mode  output  2*CH_NUM  current applied mode per channel; channel i at bits [2i+1:2i]
tick  output  1  high for one cycle at the end of each PWM period

Behaviour:
- CNT_WIDTH = bits needed to hold the value CNT_NUM.
- Period counter cnt runs 0..CNT_NUM-1 and wraps. tick = (cnt == CNT_NUM-1), combinational.
- Shared blink counter advances on each tick. blink_phase toggles on every BLINK_DIV-th tick. Reset value: phase 0.
- Per-channel state: level [CNT_WIDTH], dir (0=up), mode [2]. Level updates only on tick edges, so a new level is used from cnt=0.
- Per-mode level rules:
  - OFF: level=0.
  - ON: level=CNT_NUM.
  - BLINK: level = blink_phase ? CNT_NUM : 0, using the post-update phase.
  - BREATH, up (dir=0): if level >= CNT_NUM-1, set dir=1 and hold level; else level+1.
  - BREATH, down (dir=1): if level == 0, set dir=0 and hold level; else level-1.
  - BREATH gives a triangle of period 2*CNT_NUM ticks, holding one tick at each extreme.
- Output: led[i] = (cnt < level[i]) ? 0 : 1. level=0 gives always 1 (dark); level=CNT_NUM gives always 0 (lit).
- Command pending register (one entry):
  - cmd_ready = !pending.
  - On cmd_valid && cmd_ready: capture ch and mode; pending=1.
  - At the first tick strictly after the capture cycle: apply the command and clear pending. cmd_ready returns high the cycle after the tick.
  - A command captured in a tick cycle waits for the following tick.
- Applying a command:
  - Channel mode is set to the new mode. Other channels are unaffected.
  - Entering BREATH, including re-issuing BREATH, restarts the ramp: level=0, dir=0, then normal stepping from the next tick. Its first applied level is 0.
  - OFF, ON and BLINK take their level on the applying tick.
  - cmd_ch >= CH_NUM: the command is accepted and dropped at the tick; no state changes.
- Reset (async, rst=0): cnt=0, all modes OFF, levels 0, dir 0, pending 0, blink counter and phase 0.
- Outputs during and after reset: led all 1, ch_mode all 0, cmd_ready=1.
- Reset asserted mid-ramp or mid-pending discards all state; no command survives reset.
- cmd_valid while cmd_ready=0 is ignored. The requester must hold it until the handshake completes.

Optional Feature:
LED_ACTIVE_HIGH_EN
- Defined: led[i] = (cnt < level[i]) ? 1 : 0. Reset and OFF drive led=0.
- Undefined: active-low as described above. No other behaviour changes.

Decomposition:
- Package led_pkg: mode encodings (MODE_OFF, MODE_ON, MODE_BREATH, MODE_BLINK), mode typedef, get_width function.
- Sub-module led_seq_ch: one channel's level, dir and mode registers, the per-mode update on tick, and PWM compare. Instantiated CH_NUM times via generate.
- Top level holds: period counter, blink counter and the command pending register.

Test Plan:
- All scenarios use CH_NUM=2, CNT_NUM=4, BLINK_DIV=2.
- Reset release: led=2'b11, ch_mode=0, cmd_ready=1, tick every 4th cycle from cnt=0.
- BREATH on ch0 -> ch_mode[1:0]=2 after the next tick. Levels over successive periods: 0,1,2,3,3,2,1,0,0,1; ch0 low cycles per period match the level; ch1 stays 1.
- ON ch1, then OFF ch1 -> after each applying tick, led[1]=0 for all 4 cycles, then 1 for all cycles. Checks the boundary levels CNT_NUM and 0.
- Handshake: cmd_valid held high with 2 commands back-to-back -> second accepted only the cycle after the first's applying tick. A command issued on a tick cycle applies one full period later.
- BLINK ch0 -> led[0] alternates 8 cycles lit / 8 cycles dark. cmd_ch=3 -> accepted, no ch_mode change.
- Assert rst mid-BREATH with a pending command -> immediate led=2'b11; after release ch_mode=0 and the pending command is lost. Rerun the whole suite with LED_ACTIVE_HIGH_EN and check the inverted led values.
